// File: rtl/rll_restore_seq.sv
// Run-length-limit restore stage: applies one low-end restore record per clock to a
// base-4 word, then holds the right-justified payload, its length and an error flag.
// state | meaning
// IDLE  | waiting for a word (in_ready high)
// SCAN  | one record, terminator or error check per cycle
// OUT   | result held until out_ready
module rll_restore_seq #(
  parameter int M          = 20,
  parameter int IDX_DIGITS = 4,
  parameter int RUN_DIGITS = 2,
  parameter int LW         = $clog2(M + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M-1:0] word_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-1:0] word_out,
  output logic [LW-1:0]  word_out_len,
  output logic [LW-1:0]  rec_count,
  output logic           err
);

  localparam int W  = 2 * M;
  localparam int IW = 2 * IDX_DIGITS;
  localparam int SW = ((IW > LW) ? IW : LW) + 3;

  localparam logic signed [SW-1:0] M_S    = SW'(M);
  localparam logic signed [SW-1:0] M1_S   = SW'(M - 1);
  localparam logic signed [SW-1:0] IDX_S  = SW'(IDX_DIGITS);
  localparam logic signed [SW-1:0] HDR_S  = SW'(IDX_DIGITS + 1);
  localparam logic signed [SW-1:0] RUN1_S = SW'(RUN_DIGITS - 1);
  localparam logic [LW-1:0]        M_U    = LW'(M);
  localparam logic [LW-1:0]        HDR_U  = LW'(IDX_DIGITS + 1);
  localparam logic [LW-1:0]        RUN_U  = LW'(RUN_DIGITS);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   word_q, word_d;
  logic [LW-1:0]  p_q, p_d;
  logic [LW-1:0]  removed_q, removed_d;
  logic [LW-1:0]  rec_q, rec_d;
  logic           err_q, err_d;
  logic [W-1:0]   wout_q, wout_d;
  logic [LW-1:0]  len_q, len_d;
  logic           rdy_q, vld_q;

  logic [1:0]            flag;
  logic [IW-1:0]         idx;
  logic signed [SW-1:0]  p_s, rem_s, idx_s, t_s, lo_s;
  logic [LW-1:0]         lo_u;
  logic [31:0]           sh_p, sh_idx, sh_lo, sh_hi;
  logic [W-1:0]          low_mask, squeezed;

  // Record decode at the current scan position; the index is read relative to the
  // top of the still-valid payload, so the zero-filled region is never addressed.
  always_comb begin
    sh_p     = 32'(p_q) << 1;
    sh_idx   = (32'(p_q) + 32'd1) << 1;
    flag     = 2'(word_q >> sh_p);
    idx      = IW'(word_q >> sh_idx);
    p_s      = SW'(p_q);
    rem_s    = SW'(removed_q);
    idx_s    = SW'(idx);
    t_s      = M1_S - rem_s - idx_s;
    lo_s     = t_s - RUN1_S;
    lo_u     = lo_s[LW-1:0];
    sh_lo    = 32'(lo_u) << 1;
    sh_hi    = (32'(lo_u) + 32'(RUN_DIGITS)) << 1;
    low_mask = (W'(1) << sh_lo) - W'(1);
    squeezed = ((word_q >> sh_hi) << sh_lo) | (word_q & low_mask);
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    p_d       = p_q;
    removed_d = removed_q;
    rec_d     = rec_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          word_d    = word_in;
          p_d       = '0;
          removed_d = '0;
          rec_d     = '0;
          err_d     = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        state_d = OUT;
        if (p_s >= M_S) begin
          err_d = 1'b1;
        end else if (flag == 2'b00) begin
          p_d = p_q + 1'b1;
        end else if ((p_s + IDX_S) > M1_S) begin
          err_d = 1'b1;
        end else if (lo_s < (p_s + HDR_S)) begin
          err_d = 1'b1;
        end else begin
          word_d    = squeezed;
          p_d       = p_q + HDR_U;
          removed_d = removed_q + RUN_U;
          rec_d     = rec_q + 1'b1;
          state_d   = SCAN;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers load only on the SCAN->OUT step and then stay frozen.
  always_comb begin
    wout_d = wout_q;
    len_d  = len_q;
    if (state_q == SCAN && state_d == OUT) begin
      if (err_d) begin
        wout_d = '0;
        len_d  = '0;
      end else begin
        wout_d = word_d >> (32'(p_d) << 1);
        len_d  = M_U - p_d - removed_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      p_q       <= '0;
      removed_q <= '0;
      rec_q     <= '0;
      err_q     <= 1'b0;
      wout_q    <= '0;
      len_q     <= '0;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      p_q       <= p_d;
      removed_q <= removed_d;
      rec_q     <= rec_d;
      err_q     <= err_d;
      wout_q    <= wout_d;
      len_q     <= len_d;
      rdy_q     <= (state_d == IDLE);
      vld_q     <= (state_d == OUT);
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = vld_q;
  assign word_out     = wout_q;
  assign word_out_len = len_q;
  assign rec_count    = rec_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rll_restore_seq.sv
// Bench for rll_restore_seq (M=8, IDX_DIGITS=2, RUN_DIGITS=2): directed cases plus
// random words checked against a digit-queue reference model.
module tb_rll_restore_seq;

  localparam int M   = 8;
  localparam int IDX = 2;
  localparam int RUN = 2;
  localparam int LW  = $clog2(M + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*M-1:0] word_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*M-1:0] word_out;
  logic [LW-1:0]  word_out_len;
  logic [LW-1:0]  rec_count;
  logic           err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rll_restore_seq #(.M(M), .IDX_DIGITS(IDX), .RUN_DIGITS(RUN), .LW(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .word_in(word_in),
    .out_valid(out_valid), .out_ready(out_ready), .word_out(word_out),
    .word_out_len(word_out_len), .rec_count(rec_count), .err(err)
  );

  // Payload as a queue of digits; each record literally removes RUN entries.
  function automatic void model(input logic [15:0] w, output logic [15:0] wo, output int len,
                                output int rc, output logic e, output int steps);
    int q[$];
    int p, removed, idx, t, d;
    for (int i = 0; i < M; i++) q.push_back(int'((w >> (2 * i)) & 16'h3));
    p = 0; removed = 0; rc = 0; e = 1'b0; steps = 0; wo = '0; len = 0;
    while (steps < 4 * M) begin
      steps++;
      if (p >= M) begin e = 1'b1; break; end
      d = (p < q.size()) ? q[p] : 0;
      if (d == 0) begin p++; break; end
      if (p + IDX > M - 1) begin e = 1'b1; break; end
      idx = 0;
      for (int j = IDX; j >= 1; j--) idx = idx * 4 + ((p + j < q.size()) ? q[p + j] : 0);
      t = M - 1 - removed - idx;
      if (t - RUN + 1 < p + 1 + IDX) begin e = 1'b1; break; end
      for (int k = 0; k < RUN; k++) q.delete(t - RUN + 1);
      removed += RUN;
      p += 1 + IDX;
      rc++;
    end
    if (!e) begin
      len = q.size() - p;
      for (int i = p; i < q.size(); i++) wo |= 16'(q[i]) << (2 * (i - p));
    end
  endfunction

  // Stimulus only: hands over one word, waits for the result, optionally stalls out_ready.
  task automatic send_word(input logic [15:0] w, input int stall, output int lat,
                           output logic [15:0] wo, output int len, output int rc, output logic e);
    int n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    word_in   = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    word_in  = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
    repeat (stall) begin @(posedge clk); #1; end
    wo  = word_out;
    len = int'(word_out_len);
    rc  = int'(rec_count);
    e   = err;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (word_out !== 16'h0) begin bad++; $display("FAIL reset_word_out: got %h want 0", word_out); end
    total++; if (word_out_len !== '0) begin bad++; $display("FAIL reset_len: got %0d want 0", word_out_len); end
    total++; if (rec_count !== '0) begin bad++; $display("FAIL reset_rec_count: got %0d want 0", rec_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_held_in_ready: got %b want 0", in_ready); end
    #2 rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_before_edge: got %b want 0", in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_terminator();
    int lat, len, rc; logic [15:0] wo; logic e;
    send_word(16'hABCC, 0, lat, wo, len, rc, e);
    total++; if (lat !== 1) begin bad++; $display("FAIL term_latency: got %0d want 1", lat); end
    total++; if (wo !== 16'h2AF3) begin bad++; $display("FAIL term_word: got %h want 2af3", wo); end
    total++; if (len !== 7) begin bad++; $display("FAIL term_len: got %0d want 7", len); end
    total++; if (rc !== 0) begin bad++; $display("FAIL term_rec: got %0d want 0", rc); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL term_err: got %b want 0", e); end
  endtask

  task automatic test_one_record();
    int lat, len, rc; logic [15:0] wo; logic e;
    send_word(16'h9E05, 0, lat, wo, len, rc, e);
    total++; if (lat !== 2) begin bad++; $display("FAIL rec1_latency: got %0d want 2", lat); end
    total++; if (wo !== 16'h000A) begin bad++; $display("FAIL rec1_word: got %h want 000a", wo); end
    total++; if (len !== 2) begin bad++; $display("FAIL rec1_len: got %0d want 2", len); end
    total++; if (rc !== 1) begin bad++; $display("FAIL rec1_rec: got %0d want 1", rc); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL rec1_err: got %b want 0", e); end
  endtask

  task automatic test_errors();
    int lat, len, rc; logic [15:0] wo; logic e;
    logic [15:0] words [4] = '{16'h0015, 16'hFFFF, 16'h5555, 16'h0045};
    int          want_lat [4] = '{1, 1, 1, 2};
    int          want_rc  [4] = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      send_word(words[i], 0, lat, wo, len, rc, e);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL err_flag[%h]: got %b want 1", words[i], e); end
      total++; if (wo !== 16'h0) begin bad++; $display("FAIL err_word[%h]: got %h want 0", words[i], wo); end
      total++; if (len !== 0) begin bad++; $display("FAIL err_len[%h]: got %0d want 0", words[i], len); end
      total++; if (rc !== want_rc[i]) begin bad++; $display("FAIL err_rec[%h]: got %0d want %0d", words[i], rc, want_rc[i]); end
      total++; if (lat !== want_lat[i]) begin bad++; $display("FAIL err_latency[%h]: got %0d want %0d", words[i], lat, want_lat[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    word_in   = 16'h9E05;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid_rise: got %b want 1", out_valid); end
    in_valid = 1'b1;
    word_in  = 16'hABCC;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      total++; if (word_out !== 16'h000A) begin bad++; $display("FAIL bp_word[%0d]: got %h want 000a", c, word_out); end
      total++; if (word_out_len !== 4'd2) begin bad++; $display("FAIL bp_len[%0d]: got %0d want 2", c, word_out_len); end
      total++; if (rec_count !== 4'd1) begin bad++; $display("FAIL bp_rec[%0d]: got %0d want 1", c, rec_count); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL bp_err[%0d]: got %b want 0", c, err); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_ignored_word: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, len, rc; logic [15:0] wo; logic e;
    int n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1;
    word_in  = 16'h9E05;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    total++; if (rec_count !== '0) begin bad++; $display("FAIL mid_rst_rec: got %0d want 0", rec_count); end
    total++; if (word_out !== 16'h0 || word_out_len !== '0 || err !== 1'b0) begin
      bad++; $display("FAIL mid_rst_outputs: got %h/%0d/%b want 0/0/0", word_out, word_out_len, err);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_release_ready: got %b want 1", in_ready); end
    send_word(16'hABCC, 0, lat, wo, len, rc, e);
    total++; if (lat !== 1 || wo !== 16'h2AF3 || len !== 7 || rc !== 0 || e !== 1'b0) begin
      bad++; $display("FAIL mid_rst_fresh: got lat=%0d w=%h len=%0d rc=%0d e=%b want 1/2af3/7/0/0", lat, wo, len, rc, e);
    end
  endtask

  task automatic test_random();
    int lat, len, rc, m_len, m_rc, m_steps, stall;
    logic [15:0] wo, m_wo, w;
    logic e, m_e;
    for (int it = 0; it < 150; it++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ;
        1: w[1:0] = 2'b00;
        2: begin w[1:0] = 2'($urandom_range(1, 3)); w[5:4] = 2'b00; w[7:6] = 2'b00; end
        default: begin w[1:0] = 2'($urandom_range(1, 3)); w[5:4] = 2'b00; end
      endcase
      stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      model(w, m_wo, m_len, m_rc, m_e, m_steps);
      send_word(w, stall, lat, wo, len, rc, e);
      total++; if (lat !== m_steps) begin bad++; $display("FAIL rnd_latency[%0d w=%h]: got %0d want %0d", it, w, lat, m_steps); end
      total++; if (wo !== m_wo) begin bad++; $display("FAIL rnd_word[%0d w=%h]: got %h want %h", it, w, wo, m_wo); end
      total++; if (len !== m_len) begin bad++; $display("FAIL rnd_len[%0d w=%h]: got %0d want %0d", it, w, len, m_len); end
      total++; if (rc !== m_rc) begin bad++; $display("FAIL rnd_rec[%0d w=%h]: got %0d want %0d", it, w, rc, m_rc); end
      total++; if (e !== m_e) begin bad++; $display("FAIL rnd_err[%0d w=%h]: got %b want %b", it, w, e, m_e); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_terminator();
    test_one_record();
    test_errors();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rll_restore_seq.md
# rll_restore_seq

Multi-cycle, parametrised run-length-limit restore stage for the DNA read path. It accepts one M-digit base-4 word (2 bits per digit) that carries low-end restore records. It then applies one record per clock, deleting RUN_DIGITS payload digits per record. It emits the compacted payload right-justified, with its digit length and an error flag. It sits downstream of the digit-packing logic and replaces the single-cycle combinational restore on wide or deep words. Handshakes on both sides allow stalling.

## Interface
- M, 20: digits per word; word width 2*M bits; M >= 2+IDX_DIGITS.
- IDX_DIGITS, 4: base-4 digits per record index field.
- RUN_DIGITS, 2: digits deleted per record, >= 1.
- LW, $clog2(M+1): width of length/count outputs.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  word_in valid.
- in_ready  out  1  block can accept a word.
- word_in  in  2*M  input word; digit k = word_in[2k+1:2k].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- word_out  out  2*M  restored payload, right-justified, zero-filled above.
- word_out_len  out  LW  payload length in digits.
- rec_count  out  LW  records applied.
- err  out  1  malformed word; word_out and word_out_len are 0 when set.

## Operation
- Record format, starting at digit p = 0:
  - Flag digit p: 00 is the terminator; non-zero means a record follows.
  - Index idx is digits p+IDX_DIGITS (most significant) down to p+1, read as base-4.
- State machine: IDLE, SCAN, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: load word_in and clear p, removed, rec_count and err. Go to SCAN.
- SCAN, one step per cycle:
  - p >= M: err, go to OUT.
  - Digit p == 00: p <= p+1, go to OUT.
  - p+IDX_DIGITS > M-1 (truncated record): err, go to OUT.
  - Otherwise compute t = M-1-removed-idx. Use signed arithmetic at least LW+2 bits wide.
  - If t-RUN_DIGITS+1 < p+1+IDX_DIGITS (overlaps the header, or idx is out of range): err, go to OUT.
  - Else delete digits t..t-RUN_DIGITS+1. Digits above t shift down by RUN_DIGITS, and the top RUN_DIGITS digits become 0. Then p <= p+1+IDX_DIGITS, removed <= removed+RUN_DIGITS, rec_count <= rec_count+1. Stay in SCAN.
- idx is counted from the top of the current valid payload, so later records never address the zero-filled region.
- OUT:
  - out_valid = 1.
  - word_out = word >> 2p.
  - word_out_len = M-p-removed.
  - On error: word_out = 0, word_out_len = 0, err = 1, and rec_count holds the records applied before the failure.
  - All outputs are held stable until out_ready. On out_valid & out_ready, go to IDLE.

## Timing
- Reset (rst = 0, asynchronous):
  - State is IDLE; out_valid, word_out, word_out_len, rec_count and err are 0.
  - in_ready is 0 while rst = 0 and is 1 from the first rising edge after release.
- in_ready = 1 only in IDLE. There is no overlap between an accepted input and a pending output.
- Latency: a word with R applied records asserts out_valid R+1 cycles after the accepting edge. R = 0 gives 1 cycle.
- An error detected on step s asserts out_valid s cycles after acceptance.
- Worst case is floor(M/(1+IDX_DIGITS))+1 SCAN cycles.
- Every output is registered; no combinational path from in_valid/out_ready to outputs except in_ready, which is driven by state.
- out_ready held low keeps OUT indefinitely with bit-stable outputs.
- in_valid while not in IDLE is ignored, and the word is not captured.
- Reset asserted in SCAN or OUT aborts immediately to reset values; the partial result is lost.

## Test plan
All directed tests use M=8, IDX_DIGITS=2, RUN_DIGITS=2.
- Terminator only: word_in=16'hABCC -> 1 cycle later out_valid, word_out=16'h2AF3, len=7, rec_count=0, err=0.
- One record (idx=1), then terminator: word_in=16'h9E05 -> 2 cycles later word_out=16'h000A, len=2, rec_count=1, err=0.
- Header overlap: word_in=16'h0015 (idx=5, t=2) -> 1 cycle later err=1, word_out=0, len=0, rec_count=0.
- Truncated or unterminated: word_in=16'hFFFF -> err=1 (first record fails the range check); word_in=16'h5555 -> err=1.
- Backpressure: with out_ready=0 for 5 cycles after 16'h9E05, outputs stay stable and in_ready=0. A second in_valid is ignored. Raising out_ready returns to IDLE and in_ready=1 the next cycle.
- Reset mid-SCAN: assert rst=0 one cycle after accepting 16'h9E05 -> out_valid=0, all outputs 0 immediately. After release, in_ready=1 and a fresh 16'hABCC completes normally.
